// File: rtl/or4_response_checker.sv
// Response checker for an N-input OR/NOR gate: samples each settled input vector, counts mismatches
// and pattern coverage, and reports done/pass. Optional macro FIRST_FAIL_CAPTURE_EN adds first-fail capture.
module or4_response_checker #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 2,
   parameter int INVERT = 0,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N_IN-1:0]   vec,
   input  logic              dut_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [N_IN:0]     cov_cnt,
   output logic              smp_vld
`ifdef FIRST_FAIL_CAPTURE_EN
   ,
   output logic              ff_vld,
   output logic [N_IN-1:0]   ff_vec,
   output logic              ff_out
`endif
);

   localparam int   N_PAT   = 2**N_IN;
   localparam int   STAB_W  = $clog2(SETTLE + 1);
   localparam logic INV_BIT = (INVERT != 0);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SETTLE, S_DONE} state_t;

   state_t             r_state;
   logic [N_IN-1:0]    r_vec_q;
   logic [STAB_W-1:0]  r_stab_cnt;
   logic               r_sampled;
   logic [N_PAT-1:0]   r_cov_map;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;
   logic [ERR_W-1:0]   r_err_cnt;
   logic [N_IN:0]      r_cov_cnt;
   logic               r_smp_vld;

   logic               w_exp;
   logic               w_mismatch;
   logic [ERR_W-1:0]   w_err_next;
   logic               w_cov_hit;
   logic [N_IN:0]      w_cov_next;
   logic               w_full;
   logic               w_vec_chg;

   assign w_exp      = (|r_vec_q) ^ INV_BIT;
   assign w_mismatch = (dut_out != w_exp);
   // Saturating error increment: stays pinned at all-ones once reached.
   assign w_err_next = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + ERR_W'(1) : r_err_cnt;
   assign w_cov_hit  = ~r_cov_map[r_vec_q];
   assign w_cov_next = r_cov_cnt + (N_IN+1)'(w_cov_hit);
   assign w_full     = (w_cov_next == (N_IN+1)'(N_PAT));
   assign w_vec_chg  = (vec != r_vec_q);

`ifdef FIRST_FAIL_CAPTURE_EN
   logic               r_ff_vld;
   logic [N_IN-1:0]    r_ff_vec;
   logic               r_ff_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ff_vld <= 1'b0;
         r_ff_vec <= '0;
         r_ff_out <= 1'b0;
      end else if (start && (r_state == S_IDLE || r_state == S_DONE)) begin
         r_ff_vld <= 1'b0;
         r_ff_vec <= '0;
         r_ff_out <= 1'b0;
      end else if (r_state == S_SETTLE && w_mismatch && !r_ff_vld) begin
         r_ff_vld <= 1'b1;
         r_ff_vec <= r_vec_q;
         r_ff_out <= dut_out;
      end
   end

   assign ff_vld = r_ff_vld;
   assign ff_vec = r_ff_vec;
   assign ff_out = r_ff_out;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_vec_q    <= '0;
         r_stab_cnt <= '0;
         r_sampled  <= 1'b0;
         r_cov_map  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_err_cnt  <= '0;
         r_cov_cnt  <= '0;
         r_smp_vld  <= 1'b0;
      end else begin
         r_smp_vld <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state    <= S_ARMED;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_pass     <= 1'b0;
                  r_err_cnt  <= '0;
                  r_cov_cnt  <= '0;
                  r_cov_map  <= '0;
                  r_vec_q    <= vec;
                  r_stab_cnt <= STAB_W'(1);
                  r_sampled  <= 1'b0;
               end
            end
            S_ARMED: begin
               // A change always wins: it restarts the stability window as a new vector.
               if (w_vec_chg) begin
                  r_vec_q    <= vec;
                  r_stab_cnt <= STAB_W'(1);
                  r_sampled  <= 1'b0;
               end else if (r_stab_cnt == STAB_W'(SETTLE) && !r_sampled) begin
                  r_state <= S_SETTLE;
               end else if (r_stab_cnt < STAB_W'(SETTLE)) begin
                  r_stab_cnt <= r_stab_cnt + STAB_W'(1);
               end
            end
            S_SETTLE: begin
               r_smp_vld <= 1'b1;
               r_err_cnt <= w_err_next;
               r_cov_cnt <= w_cov_next;
               if (w_cov_hit)
                  r_cov_map[r_vec_q] <= 1'b1;
               // The sample above uses the old vector; a change seen here starts a new window.
               if (w_vec_chg) begin
                  r_vec_q    <= vec;
                  r_stab_cnt <= STAB_W'(1);
                  r_sampled  <= 1'b0;
               end else begin
                  r_sampled  <= 1'b1;
               end
               if (w_full) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_next == '0);
               end else begin
                  r_state <= S_ARMED;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign pass    = r_pass;
   assign err_cnt = r_err_cnt;
   assign cov_cnt = r_cov_cnt;
   assign smp_vld = r_smp_vld;

endmodule

// File: tb/tb_or4_response_checker.sv
// Bench for or4_response_checker: segment-level reference model (sample per long-enough stable
// segment), directed sweeps/glitch/reset cases plus randomized segment streams.
module tb_or4_response_checker;

   localparam int SETTLE = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  vec;
   logic        dut_out;
   logic [15:0] flip_mask;

   logic        busy, done, pass, smp_vld;
   logic [7:0]  err_cnt;
   logic [4:0]  cov_cnt;
   logic        busy2, done2, pass2, smp_vld2;
   logic [1:0]  err_cnt2;
   logic [4:0]  cov_cnt2;
`ifdef FIRST_FAIL_CAPTURE_EN
   logic        ff_vld, ff_out, ff_vld2, ff_out2;
   logic [3:0]  ff_vec, ff_vec2;
`endif

   always #5 clk = ~clk;

   // Gate under test: a correct OR, except on patterns flagged in flip_mask.
   always_comb dut_out = (|vec) ^ flip_mask[vec];

   or4_response_checker #(.N_IN(4), .SETTLE(SETTLE), .INVERT(0), .ERR_W(8)) u_dut (
      .clk(clk), .rst(rst), .start(start), .vec(vec), .dut_out(dut_out),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .cov_cnt(cov_cnt),
      .smp_vld(smp_vld)
`ifdef FIRST_FAIL_CAPTURE_EN
      , .ff_vld(ff_vld), .ff_vec(ff_vec), .ff_out(ff_out)
`endif
   );

   or4_response_checker #(.N_IN(4), .SETTLE(SETTLE), .INVERT(0), .ERR_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .vec(vec), .dut_out(dut_out),
      .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2), .cov_cnt(cov_cnt2),
      .smp_vld(smp_vld2)
`ifdef FIRST_FAIL_CAPTURE_EN
      , .ff_vld(ff_vld2), .ff_vec(ff_vec2), .ff_out(ff_out2)
`endif
   );

   int checks = 0;
   int errors = 0;

   int seg_v[$];
   int seg_h[$];
   int q_e1[$];
   int q_e2[$];
   int q_cov[$];

   int m_err1, m_err2, m_cov, m_smp, m_done;
   int m_ff_vld, m_ff_vec, m_ff_out;
   int mon_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: a segment held for at least SETTLE+1 edges yields exactly one sample.
   task automatic model_run();
      bit map [16];
      int v, o;
      m_err1 = 0; m_err2 = 0; m_cov = 0; m_smp = 0; m_done = 0;
      m_ff_vld = 0; m_ff_vec = 0; m_ff_out = 0;
      for (int k = 0; k < 16; k++) map[k] = 1'b0;
      q_e1.delete(); q_e2.delete(); q_cov.delete();
      for (int i = 0; i < seg_v.size(); i++) begin
         if (m_done == 0 && seg_h[i] >= SETTLE + 1) begin
            v = seg_v[i];
            o = ((v != 0) ? 1 : 0) ^ int'(flip_mask[v]);
            if (o != ((v != 0) ? 1 : 0)) begin
               if (m_err1 < 255) m_err1++;
               if (m_err2 < 3) m_err2++;
               if (m_ff_vld == 0) begin
                  m_ff_vld = 1; m_ff_vec = v; m_ff_out = o;
               end
            end
            if (!map[v]) begin
               map[v] = 1'b1;
               m_cov++;
            end
            m_smp++;
            q_e1.push_back(m_err1);
            q_e2.push_back(m_err2);
            q_cov.push_back(m_cov);
            if (m_cov == 16) m_done = 1;
         end
      end
   endtask

   always @(negedge clk) begin
      if (smp_vld === 1'b1) begin
         mon_cnt++;
         checks++;
         assert (q_cov.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_sample observed vec %0d expected no sample", vec);
         end
         if (q_cov.size() > 0) begin
            check("smp_err", 32'(err_cnt), 32'(q_e1.pop_front()));
            check("smp_err_w2", 32'(err_cnt2), 32'(q_e2.pop_front()));
            check("smp_cov", 32'(cov_cnt), 32'(q_cov[0]));
            check("smp_cov_w2", 32'(cov_cnt2), 32'(q_cov.pop_front()));
            check("smp_vld_w2", 32'(smp_vld2), 32'(1));
         end
      end
   end

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mon_cnt = 0;
   endtask

   task automatic drive_segs();
      for (int i = 0; i < seg_v.size(); i++) begin
         vec = 4'(seg_v[i]);
         if (i == 0) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (seg_h[i] - 1) @(negedge clk);
         end else begin
            repeat (seg_h[i]) @(negedge clk);
         end
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic final_checks(input string tag);
      $display("run %s: samples %0d err %0d cov %0d done %0d", tag, mon_cnt, err_cnt, cov_cnt, done);
      check({tag, "_nsmp"}, 32'(mon_cnt), 32'(m_smp));
      check({tag, "_pending"}, 32'(q_cov.size()), 32'(0));
      check({tag, "_err"}, 32'(err_cnt), 32'(m_err1));
      check({tag, "_err_w2"}, 32'(err_cnt2), 32'(m_err2));
      check({tag, "_cov"}, 32'(cov_cnt), 32'(m_cov));
      check({tag, "_done"}, 32'(done), 32'(m_done));
      check({tag, "_done_w2"}, 32'(done2), 32'(m_done));
      check({tag, "_busy"}, 32'(busy), 32'(m_done == 0));
      if (m_done != 0) begin
         check({tag, "_pass"}, 32'(pass), 32'(m_err1 == 0));
         check({tag, "_pass_w2"}, 32'(pass2), 32'(m_err2 == 0));
      end
`ifdef FIRST_FAIL_CAPTURE_EN
      check({tag, "_ff_vld"}, 32'(ff_vld), 32'(m_ff_vld));
      if (m_ff_vld != 0) begin
         check({tag, "_ff_vec"}, 32'(ff_vec), 32'(m_ff_vec));
         check({tag, "_ff_out"}, 32'(ff_out), 32'(m_ff_out));
      end
`endif
   endtask

   task automatic build_sweep(input int n);
      seg_v.delete(); seg_h.delete();
      for (int v = 0; v < n; v++) begin
         seg_v.push_back(v);
         seg_h.push_back(10);
      end
   endtask

   task automatic run_full(input string tag);
      pulse_rst();
      model_run();
      drive_segs();
      final_checks(tag);
   endtask

   initial begin
      int cyc, prev, v;
      rst = 1'b1; start = 1'b0; vec = 4'd0; flip_mask = 16'h0000; mon_cnt = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_pass", 32'(pass), 32'(0));
      check("rst_smp", 32'(smp_vld), 32'(0));
      check("rst_err", 32'(err_cnt), 32'(0));
      check("rst_cov", 32'(cov_cnt), 32'(0));

      // First-sample latency after start.
      pulse_rst();
      seg_v = '{5}; seg_h = '{20};
      model_run();
      vec = 4'd5; start = 1'b1; cyc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (smp_vld === 1'b1) break;
      end
      $display("latency: first sample seen after %0d cycles", cyc);
      check("latency", 32'(cyc), 32'(SETTLE + 2));
      repeat (20) @(negedge clk);
      final_checks("latency");

      flip_mask = 16'h0000; build_sweep(16); run_full("sweep_or");
      check("sweep_or_cov16", 32'(cov_cnt), 32'(16));
      // Re-arm from DONE: done drops right after the start edge.
      start = 1'b1; vec = 4'd3;
      @(negedge clk);
      start = 1'b0;
      check("rearm_done", 32'(done), 32'(0));
      check("rearm_busy", 32'(busy), 32'(1));
      check("rearm_cov", 32'(cov_cnt), 32'(0));

      flip_mask = 16'hFFFE; build_sweep(16); run_full("sweep_stuck0");
      check("stuck0_err15", 32'(err_cnt), 32'(15));
      flip_mask = 16'hFFFF; build_sweep(16); run_full("sweep_invert");
      check("invert_sat3", 32'(err_cnt2), 32'(3));
      flip_mask = 16'h1200; build_sweep(16); run_full("sweep_ff");

      // Glitch 0101 -> 0111 for one cycle, then a long hold of 0101.
      flip_mask = 16'h0000;
      seg_v = '{5, 7, 5}; seg_h = '{6, 1, 30};
      run_full("glitch");
      check("glitch_cov", 32'(cov_cnt), 32'(1));

      // Reset after 7 patterns, with a start pulse ignored while busy.
      flip_mask = 16'hFFFE; build_sweep(7); run_full("partial");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("busy_start_cov", 32'(cov_cnt), 32'(7));
      check("busy_start_err", 32'(err_cnt), 32'(6));
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_err", 32'(err_cnt), 32'(0));
      check("midrst_cov", 32'(cov_cnt), 32'(0));
      rst = 1'b0;
      flip_mask = 16'h0000; build_sweep(16); run_full("after_rst");

      for (int r = 0; r < 6; r++) begin
         case (r % 3)
            0: flip_mask = 16'h0000;
            1: flip_mask = 16'($urandom & $urandom);
            default: flip_mask = 16'(1 << $urandom_range(0, 15));
         endcase
         seg_v.delete(); seg_h.delete();
         prev = -1;
         for (int i = 0; i < 50; i++) begin
            do v = $urandom_range(0, 15); while (v == prev);
            prev = v;
            seg_v.push_back(v);
            if (i != 49 && $urandom_range(0, 3) == 0)
               seg_h.push_back($urandom_range(1, SETTLE));
            else
               seg_h.push_back($urandom_range(SETTLE + 2, SETTLE + 6));
         end
         run_full($sformatf("rand%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
